aer_rate_encoder: RTL and testbench

N-channel AER (address-event representation) encoder for the SNN input stage. Each channel is a multi-bit pixel intensity. Intensity is mapped to a spike period, and each channel has its own staggered-phase countdown. Spikes are buffered in per-channel pending flags, round-robin arbitrated onto a single AER bus with a valid/ready handshake, and any overrun is counted. The block sits between the pixel source and the AER neuron array, and handles collisions losslessly.

---
 rtl/aer_rate_encoder_if.sv | 16 +
 rtl/aer_rate_encoder.sv | 143 ++++++++++++++
 tb/tb_aer_rate_encoder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aer_rate_encoder_if.sv
// AER output bus: a single event address with a valid/ready handshake.
//
// Handshake: an event transfers on every rising clk edge where aer_valid and
// aer_ready are both 1. Once the master raises aer_valid, it holds aer_valid and
// aer_addr stable until that transfer happens, so an event is never withdrawn.
// The slave may drive aer_ready freely, and aer_ready may depend on aer_valid.
interface aer_rate_encoder_if #(
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] aer_addr;
  logic              aer_valid;
  logic              aer_ready;

  modport master (output aer_addr, output aer_valid, input aer_ready);
  modport slave  (input aer_addr, input aer_valid, output aer_ready);
endinterface

// File: rtl/aer_rate_encoder.sv
// N-channel rate encoder with an AER output.
// Each channel maps its pixel intensity to a spike period and counts down with a
// staggered start phase. Fired spikes wait in per-channel pending flags. A
// round-robin arbiter moves them onto one AER bus. A spike that finds its own
// channel's flag still set is lost and counted in a saturating drop counter.
module aer_rate_encoder #(
  parameter int NUM_CH       = 4,
  parameter int PIXEL_WIDTH  = 4,
  parameter int CNT_WIDTH    = 8,
  parameter int BASE_PERIOD  = 4,
  parameter int STEP_SHIFT   = 1,
  parameter int QUIET_PERIOD = 100,
  parameter int PHASE_STEP   = 1,
  parameter int DROP_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_CH*PIXEL_WIDTH-1:0] pixels_in,
  output logic [NUM_CH-1:0]             spike_out,
  aer_rate_encoder_if.master            aer,
  output logic [DROP_WIDTH-1:0]         drop_cnt,
  input  logic                          drop_clr
);

  localparam int     ADDR_W  = $clog2(NUM_CH);
  localparam int     SUM_W   = DROP_WIDTH + $clog2(NUM_CH + 1);
  localparam longint CNT_MAX = (longint'(1) << CNT_WIDTH) - 1;

  // Reload value (period - 1) for a pixel. The period saturates at the counter range.
  function automatic logic [CNT_WIDTH-1:0] reload_val(input logic [PIXEL_WIDTH-1:0] p);
    longint per;
    if (p == '0) begin
      per = longint'(QUIET_PERIOD);
    end else begin
      per = longint'(BASE_PERIOD) +
            (((longint'(1) << PIXEL_WIDTH) - 1 - longint'(p)) << STEP_SHIFT);
    end
    if (per > CNT_MAX) per = CNT_MAX;
    return CNT_WIDTH'(per - 1);
  endfunction

  // Start phase of channel i. It is used at reset and whenever the encoders are disabled.
  function automatic logic [CNT_WIDTH-1:0] phase_val(input int i);
    return CNT_WIDTH'(i * PHASE_STEP);
  endfunction

  logic [CNT_WIDTH-1:0]  cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [NUM_CH-1:0]     spike_q;
  logic [NUM_CH-1:0]     fire;
  logic [NUM_CH-1:0]     grant_mask;
  logic [NUM_CH-1:0]     drop_vec;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  valid_q;
  logic                  load;
  logic                  grant_vld;
  logic [ADDR_W-1:0]     grant_idx;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic [SUM_W-1:0]      drop_n, drop_sum;

  // Countdown per channel. On expiry, reload from the pixel seen that cycle;
  // a nonzero pixel also fires.
  always_comb begin
    fire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = phase_val(i);
      if (enable) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i] = reload_val(pixels_in[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
          fire[i]  = (pixels_in[i*PIXEL_WIDTH +: PIXEL_WIDTH] != '0);
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
        end
      end
    end
  end

  // Round-robin grant. The search starts at the pointer. A new event loads only
  // when the output register is empty or is being accepted this cycle.
  always_comb begin
    load       = enable && (!valid_q || aer.aer_ready);
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_mask = '0;
    if (load) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!grant_vld && pend_q[(int'(ptr_q) + k) % NUM_CH]) begin
          grant_vld = 1'b1;
          grant_idx = ADDR_W'((int'(ptr_q) + k) % NUM_CH);
        end
      end
    end
    if (grant_vld) grant_mask[grant_idx] = 1'b1;
    ptr_d = ptr_q;
    if (grant_vld) ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + ADDR_W'(1);
  end

  // Pending update: set wins over the grant clear. A fire onto a flag that is
  // still set, and not granted, is a drop.
  always_comb begin
    drop_vec = fire & pend_q & ~grant_mask;
    pend_d   = enable ? ((pend_q & ~grant_mask) | fire) : '0;
    drop_n   = '0;
    for (int i = 0; i < NUM_CH; i++) drop_n = drop_n + SUM_W'(drop_vec[i]);
    drop_sum = SUM_W'(drop_q) + drop_n;
    drop_d   = (drop_sum[SUM_W-1:DROP_WIDTH] != '0) ? '1 : drop_sum[DROP_WIDTH-1:0];
    if (drop_clr) drop_d = '0;
  end

  // State registers: counters, pending flags, pointer, AER output register, drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= phase_val(i);
      pend_q  <= '0;
      spike_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      pend_q  <= pend_d;
      spike_q <= fire;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
      if (grant_vld) begin
        addr_q  <= grant_idx;
        valid_q <= 1'b1;
      end else if (valid_q && aer.aer_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign spike_out     = spike_q;
  assign aer.aer_addr  = addr_q;
  assign aer.aer_valid = valid_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_aer_rate_encoder.sv
// Bench for aer_rate_encoder. There are two instances: the default build, and a
// build with a 2-bit drop counter for saturation. Both take the same stimulus.
// An event-time model runs every cycle. Directed scenarios pin literal values.
module tb_aer_rate_encoder;
  localparam int NUM_CH = 4;
  localparam int PW     = 4;
  localparam int BASE   = 4;
  localparam int SHIFT  = 1;
  localparam int QUIET  = 100;
  localparam int PHASE  = 1;
  localparam int CMAX   = 255;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic ready = 1'b0;
  logic drop_clr = 1'b0;
  logic [NUM_CH*PW-1:0] pixels = '0;
  logic [NUM_CH-1:0] spike_a, spike_b;
  logic [15:0] drop_a;
  logic [1:0]  drop_b;

  always #5 clk = ~clk;

  aer_rate_encoder_if #(.ADDR_W(2)) if_a ();
  aer_rate_encoder_if #(.ADDR_W(2)) if_b ();
  assign if_a.aer_ready = ready;
  assign if_b.aer_ready = ready;

  aer_rate_encoder dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixels_in(pixels),
    .spike_out(spike_a), .aer(if_a), .drop_cnt(drop_a), .drop_clr(drop_clr)
  );

  aer_rate_encoder #(.DROP_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixels_in(pixels),
    .spike_out(spike_b), .aer(if_b), .drop_cnt(drop_b), .drop_clr(drop_clr)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Channels are tracked as "next expiry time" in enabled-cycle units, not as
  // countdowns. The AER output is a single slot holding the presented event.
  int en_cyc;
  int m_next [NUM_CH];
  bit m_pend [NUM_CH];
  int m_ptr;
  bit m_valid;
  int m_addr;
  int m_drop;
  int m_drop2;
  logic [NUM_CH-1:0] m_spike;
  bit m_live = 1'b0;

  function automatic int period(input int p);
    int v;
    if (p == 0) return QUIET;
    v = BASE + ((2**PW) - 1 - p) * (2**SHIFT);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_step();
    logic [NUM_CH-1:0] fire;
    int g;
    bit have_g;
    int ndrop;
    int p;
    if (!rst_n) begin
      en_cyc = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_next[i] = (i * PHASE) % (CMAX + 1);
        m_pend[i] = 1'b0;
      end
      m_ptr = 0; m_valid = 1'b0; m_addr = 0;
      m_drop = 0; m_drop2 = 0; m_spike = '0; m_live = 1'b1;
      return;
    end
    fire = '0;
    if (enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (en_cyc == m_next[i]) begin
          p = int'(pixels[i*PW +: PW]);
          fire[i] = (p != 0);
          m_next[i] = en_cyc + period(p);
        end
      end
    end
    have_g = 1'b0;
    g = 0;
    if (enable && (!m_valid || ready)) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!have_g && m_pend[(m_ptr + k) % NUM_CH]) begin
          have_g = 1'b1;
          g = (m_ptr + k) % NUM_CH;
        end
      end
    end
    ndrop = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (fire[i] && m_pend[i] && !(have_g && g == i)) ndrop++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!enable) m_pend[i] = 1'b0;
      else if (have_g && g == i) m_pend[i] = fire[i];
      else m_pend[i] = m_pend[i] | fire[i];
    end
    if (have_g) begin
      m_valid = 1'b1; m_addr = g; m_ptr = (g + 1) % NUM_CH;
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    m_spike = fire;
    if (drop_clr) begin
      m_drop = 0; m_drop2 = 0;
    end else begin
      m_drop  = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
      m_drop2 = (m_drop2 + ndrop > 3) ? 3 : m_drop2 + ndrop;
    end
    if (enable) begin
      en_cyc++;
    end else begin
      en_cyc = 0;
      for (int i = 0; i < NUM_CH; i++) m_next[i] = (i * PHASE) % (CMAX + 1);
    end
  endtask

  // Every cycle: advance the model on the edge and compare just after it.
  always @(posedge clk) begin
    model_step();
    #1;
    if (m_live) begin
      chk("spike_a", spike_a, m_spike);
      chk("spike_b", spike_b, m_spike);
      chk("valid_a", if_a.aer_valid, m_valid);
      chk("valid_b", if_b.aer_valid, m_valid);
      if (m_valid) begin
        chk("addr_a", if_a.aer_addr, m_addr);
        chk("addr_b", if_b.aer_addr, m_addr);
      end
      chk("drop_a", drop_a, m_drop);
      chk("drop_b", drop_b, m_drop2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    chk({tag, "_spike"}, spike_a, 0);
    chk({tag, "_valid"}, if_a.aer_valid, 0);
    chk({tag, "_addr"}, if_a.aer_addr, 0);
    chk({tag, "_drop_a"}, drop_a, 0);
    chk({tag, "_drop_b"}, drop_b, 0);
  endtask

  // Returns at a negedge with rst_n released and all inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; ready = 1'b0; drop_clr = 1'b0;
    #1 check_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_cycle(input int n);
    int ch;
    ready    = ((n % 120) < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
    enable   = ($urandom_range(0, 39) != 0);
    drop_clr = ($urandom_range(0, 59) == 0);
    if ($urandom_range(0, 11) == 0) begin
      ch = $urandom_range(0, NUM_CH - 1);
      pixels[ch*PW +: PW] = PW'($urandom_range(0, 15));
    end
  endtask

  // ---------------- directed + random scenarios ----------------
  int cnt_spk [NUM_CH];
  int bad_evt;

  initial begin
    // 1: full intensity, consumer always ready.
    do_reset();
    pixels = 16'hFFFF; enable = 1'b1; ready = 1'b1;
    for (int t = 0; t <= 12; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 1) chk("s1_spike_c1", spike_a, 4'b0001);
      if (t == 2) chk("s1_spike_c2", spike_a, 4'b0010);
      if (t >= 2) begin
        chk("s1_valid", if_a.aer_valid, 1);
        chk("s1_addr", if_a.aer_addr, (t - 2) % 4);
      end
      if (t == 12) chk("s1_drop", drop_a, 0);
    end

    // 2: consumer stalled for cycles 0-9, then drains. Then clear drops under stall.
    do_reset();
    pixels = 16'hFFFF; enable = 1'b1; ready = 1'b0;
    for (int t = 0; t <= 20; t++) begin
      if (t > 0) @(negedge clk);
      if (t >= 3 && t <= 9) begin
        chk("s2_hold_valid", if_a.aer_valid, 1);
        chk("s2_hold_addr", if_a.aer_addr, 0);
      end
      if (t == 10) begin
        chk("s2_drop5", drop_a, 5);
        chk("s2_drop_sat", drop_b, 3);
        ready = 1'b1;
      end
      if (t >= 10 && t <= 14) chk("s2_drain_addr", if_a.aer_addr, (t - 10) % 4);
      if (t == 15) ready = 1'b0;
      if (t == 18) drop_clr = 1'b1;
      if (t == 19) begin
        chk("s2_clr_a", drop_a, 0);
        chk("s2_clr_b", drop_b, 0);
        drop_clr = 1'b0; ready = 1'b1;
      end
    end

    // 3: pixels {15,0,0,1} for ch3..ch0.
    do_reset();
    pixels = 16'hF001; enable = 1'b1; ready = 1'b1;
    bad_evt = 0;
    for (int i = 0; i < NUM_CH; i++) cnt_spk[i] = 0;
    for (int t = 0; t <= 70; t++) begin
      if (t > 0) @(negedge clk);
      if (t >= 1) for (int i = 0; i < NUM_CH; i++) cnt_spk[i] += int'(spike_a[i]);
      if (if_a.aer_valid && (if_a.aer_addr == 2'd1 || if_a.aer_addr == 2'd2)) bad_evt++;
      if (t == 33) chk("s3_ch0_c33", spike_a[0], 1);
    end
    chk("s3_ch0_cnt", cnt_spk[0], 3);
    chk("s3_ch1_cnt", cnt_spk[1], 0);
    chk("s3_ch2_cnt", cnt_spk[2], 0);
    chk("s3_ch3_cnt", cnt_spk[3], 17);
    chk("s3_quiet_evt", bad_evt, 0);

    // 4: ch0 drops from 15 to 14 mid-period.
    do_reset();
    pixels = 16'hFFFF; enable = 1'b1; ready = 1'b1;
    for (int t = 0; t <= 16; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 5) pixels[3:0] = 4'd14;
      if (t == 9)  chk("s4_spike_c9", spike_a[0], 1);
      if (t == 13) chk("s4_spike_c13", spike_a[0], 0);
      if (t == 15) chk("s4_spike_c15", spike_a[0], 1);
    end

    // 5: disable while an event is stalled, then accept it and re-enable.
    do_reset();
    pixels = 16'hFFFF; enable = 1'b1; ready = 1'b0;
    for (int t = 0; t <= 16; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 6) enable = 1'b0;
      if (t == 7 || t == 8) begin
        chk("s5_hold_valid", if_a.aer_valid, 1);
        chk("s5_hold_addr", if_a.aer_addr, 0);
        chk("s5_no_spike", spike_a, 0);
      end
      if (t == 9) ready = 1'b1;
      if (t == 10) chk("s5_released", if_a.aer_valid, 0);
      if (t == 12) enable = 1'b1;
      if (t == 13) chk("s5_restart_c13", spike_a, 4'b0001);
      if (t == 14) begin
        chk("s5_restart_c14", spike_a, 4'b0010);
        chk("s5_first_addr", if_a.aer_addr, 0);
      end
    end

    // 6: random traffic, then an asynchronous reset pulse mid-stream, then more traffic.
    do_reset();
    for (int i = 0; i < NUM_CH; i++) pixels[i*PW +: PW] = PW'($urandom_range(0, 15));
    for (int n = 0; n < 600; n++) begin
      rand_cycle(n);
      @(negedge clk);
    end
    ready = 1'b0; enable = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 300; n++) begin
      rand_cycle(n);
      @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
